// File: rtl/clk_div_mc.sv
// clk_div_mc: CH-channel programmable divided clock and tick generator.
// Define CLK_DIV_MC_SHADOW_EN to defer divisor changes to period boundaries, sync or disable.
module clk_div_mc #(
  parameter int W       = 16,
  parameter int CH      = 4,
  parameter int DEF_DIV = 20
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] div_in,
  input  logic            div_load,
  input  logic            sync,
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic            busy
);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);
  localparam logic [W-1:0] DEF = W'(DEF_DIV);
  logic [CH-1:0] pf_v;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] din, cnt_q, cnt_d, act_q, act_d, e_cur, e_nxt;
    logic         run_q, clk_q, clk_d, tick_q, tick_d, wrap, restart;
`ifdef CLK_DIV_MC_SHADOW_EN
    logic [W-1:0] pend_q, pend_d;
    logic         pf_q, pf_d, apply;
`endif
    assign din = div_in[i*W +: W];
    always_comb begin
      e_cur   = (act_q < TWO) ? TWO : act_q;
      wrap    = cnt_q >= e_cur - ONE;
`ifdef CLK_DIV_MC_SHADOW_EN
      apply   = sync | ~en[i] | ~run_q | wrap;
      act_d   = (sync & div_load) ? din : apply ? pend_q : act_q;
      pend_d  = div_load ? din : pend_q;
      pf_d    = div_load ? ~sync : pf_q & ~apply;
      restart = sync;
`else
      act_d   = div_load ? din : act_q;
      restart = sync | div_load;
`endif
      // run_q low means the channel was idle last cycle, so this edge starts at phase 0
      cnt_d   = (~en[i] | ~run_q | restart | wrap) ? '0 : cnt_q + ONE;
      e_nxt   = (act_d < TWO) ? TWO : act_d;
      clk_d   = en[i] & (cnt_d < e_nxt - (e_nxt >> 1));
      tick_d  = en[i] & (cnt_d == '0);
    end
    always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DEF;
        run_q  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
`ifdef CLK_DIV_MC_SHADOW_EN
        pend_q <= DEF;
        pf_q   <= 1'b0;
`endif
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        run_q  <= en[i];
        clk_q  <= clk_d;
        tick_q <= tick_d;
`ifdef CLK_DIV_MC_SHADOW_EN
        pend_q <= pend_d;
        pf_q   <= pf_d;
`endif
      end
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
`ifdef CLK_DIV_MC_SHADOW_EN
    assign pf_v[i] = pf_q;
`else
    assign pf_v[i] = 1'b0;
`endif
  end
  assign busy = |pf_v;
endmodule
